bin_to_bcd_par: RTL and testbench

BIN_TO_BCD_PAR -- requirements
Module: bin_to_bcd_par

---
 rtl/bin_to_bcd_par.sv | 165 ++++++++++++++++
 tb/tb_bin_to_bcd_par.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_par.sv
// bin_to_bcd_par: sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   st       - start strobe; sgn and Dbin are sampled with it while idle
//   sgn      - 0: Dbin is unsigned, 1: Dbin is two's complement
//   Dbin     - binary operand, NBIN bits
//   Ddec     - packed BCD result, digit i at [4i+3:4i]
//   neg      - result sign (negative operand in signed mode)
//   ovf      - magnitude did not fit in NDIG digits
//   ptr_dig  - index of most significant nonzero digit (NDIG-1 on overflow)
//   busy     - conversion in progress
//   done     - one-cycle pulse when the result outputs update
module bin_to_bcd_par #(
    parameter int unsigned NBIN = 27,
    parameter int unsigned NDIG = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                st,
    input  logic                sgn,
    input  logic [NBIN-1:0]     Dbin,
    output logic [4*NDIG-1:0]   Ddec,
    output logic                neg,
    output logic                ovf,
    output logic [3:0]          ptr_dig,
    output logic                busy,
    output logic                done
);

    localparam int unsigned BW = 4 * NDIG;
    localparam int unsigned CW = $clog2(NBIN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            load_c;
    logic            shift_c;
    logic            finish_c;

    logic [BW-1:0]   acc_q;
    logic [NBIN-1:0] mag_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;
    logic            neg_q;

    logic [NBIN-1:0] mag_in_c;
    logic            neg_in_c;
    logic [BW-1:0]   adj_c;
    logic [3:0]      ptr_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        shift_c  = 1'b0;
        finish_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (st) begin
                    load_c  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                shift_c = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                finish_c = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand magnitude and sign; the most negative value negates to itself,
    // which read as unsigned is exactly 2^(NBIN-1)
    always_comb begin
        neg_in_c = sgn & Dbin[NBIN-1];
        mag_in_c = neg_in_c ? (~Dbin + NBIN'(1)) : Dbin;
    end

    // Add-3 correction on every digit >= 5 ahead of the shift
    always_comb begin
        adj_c = acc_q;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Most significant nonzero digit of the finished accumulator
    always_comb begin
        ptr_c = 4'd0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (acc_q[4*i +: 4] != 4'd0) begin
                ptr_c = 4'(i);
            end
        end
        if (ovf_q) begin
            ptr_c = 4'(NDIG - 1);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            Ddec    <= '0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
            ptr_dig <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            done <= finish_c;
            if (load_c) begin
                acc_q <= '0;
                mag_q <= mag_in_c;
                cnt_q <= CW'(NBIN);
                ovf_q <= 1'b0;
                neg_q <= neg_in_c;
            end
            if (shift_c) begin
                // Bit leaving the top digit means the value reached 10^NDIG
                acc_q <= {adj_c[BW-2:0], mag_q[NBIN-1]};
                mag_q <= {mag_q[NBIN-2:0], 1'b0};
                cnt_q <= cnt_q - CW'(1);
                ovf_q <= ovf_q | adj_c[BW-1];
            end
            if (finish_c) begin
                Ddec    <= acc_q;
                neg     <= neg_q;
                ovf     <= ovf_q;
                ptr_dig <= ptr_c;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_par.sv
// tb_bin_to_bcd_par: self-checking bench for bin_to_bcd_par (NBIN=27, NDIG=8).
module tb_bin_to_bcd_par;

    localparam int unsigned NBIN = 27;
    localparam int unsigned NDIG = 8;
    localparam int          LAT  = NBIN + 1;

    logic              clk;
    logic              rst;
    logic              st;
    logic              sgn;
    logic [NBIN-1:0]   Dbin;
    logic [4*NDIG-1:0] Ddec;
    logic              neg;
    logic              ovf;
    logic [3:0]        ptr_dig;
    logic              busy;
    logic              done;

    int errors;
    int checks;

    bin_to_bcd_par #(.NBIN(NBIN), .NDIG(NDIG)) dut (
        .clk     (clk),
        .rst     (rst),
        .st      (st),
        .sgn     (sgn),
        .Dbin    (Dbin),
        .Ddec    (Ddec),
        .neg     (neg),
        .ovf     (ovf),
        .ptr_dig (ptr_dig),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference: plain integer arithmetic on the magnitude
    function automatic void model(input logic s, input logic [NBIN-1:0] d,
                                  output logic [4*NDIG-1:0] e_dec, output logic e_neg,
                                  output logic e_ovf, output logic [3:0] e_ptr);
        longint unsigned mag;
        longint unsigned r;
        e_neg = s && d[NBIN-1];
        if (e_neg) mag = (64'd1 << NBIN) - 64'(d);
        else       mag = 64'(d);
        e_ovf = (mag >= 64'd100000000);
        r = mag % 64'd100000000;
        e_dec = '0;
        e_ptr = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            e_dec[4*i +: 4] = 4'(r % 64'd10);
            if ((r % 64'd10) != 0) e_ptr = 4'(i);
            r = r / 64'd10;
        end
        if (e_ovf) e_ptr = 4'(NDIG - 1);
    endfunction

    // Called at a negedge; returns at the negedge just after the st-sampling edge,
    // with operand inputs scrambled to show they are not re-sampled
    task automatic start(input logic s, input logic [NBIN-1:0] d);
        st   = 1'b1;
        sgn  = s;
        Dbin = d;
        @(negedge clk);
        st   = 1'b0;
        sgn  = 1'($urandom);
        Dbin = NBIN'($urandom);
    endtask

    // Edges counted after the st-sampling edge until done is seen (bounded)
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 3 * LAT);
    endtask

    task automatic test_reset;
        rst = 1'b1; st = 1'b0; sgn = 1'b0; Dbin = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({Ddec, neg, ovf, ptr_dig, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got Ddec=%h neg=%b ovf=%b ptr=%0d busy=%b done=%b, want all 0",
                     Ddec, neg, ovf, ptr_dig, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, Ddec} !== '0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b done=%b Ddec=%h, want 0", busy, done, Ddec);
        end
    endtask

    task automatic test_vectors;
        logic [NBIN-1:0]   vd  [4] = '{27'h16A9D55, 27'h7FFFFFF, 27'h7FFFFFF, 27'h4000000};
        logic              vs  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0]       vx  [4] = '{32'h23764309, 32'h34217727, 32'h00000001, 32'h67108864};
        logic              vn  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic              vo  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0]        vp  [4] = '{4'd7, 4'd7, 4'd0, 4'd7};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start(vs[i], vd[i]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_busy_start: got busy=%b, want 1", i, busy);
            end
            wait_done(0, lat);
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d, want %0d", i, lat, LAT);
            end
            checks++;
            if (Ddec !== vx[i] || neg !== vn[i] || ovf !== vo[i] || ptr_dig !== vp[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_result: got Ddec=%h neg=%b ovf=%b ptr=%0d busy=%b, want Ddec=%h neg=%b ovf=%b ptr=%0d busy=0",
                         i, Ddec, neg, ovf, ptr_dig, busy, vx[i], vn[i], vo[i], vp[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || Ddec !== vx[i] || ptr_dig !== vp[i]) begin
                errors++;
                $display("FAIL vec%0d_hold: got done=%b Ddec=%h ptr=%0d, want done=0 Ddec=%h ptr=%0d",
                         i, done, Ddec, ptr_dig, vx[i], vp[i]);
            end
        end
    endtask

    task automatic test_zero_and_ignore;
        int lat;
        int extra;
        start(1'b0, '0);
        repeat (4) @(negedge clk);
        start(1'b0, 27'h1234567);
        wait_done(5, lat);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL zero_latency: got %0d, want %0d", lat, LAT);
        end
        checks++;
        if (Ddec !== '0 || ptr_dig !== 4'd0 || neg !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL zero_result: got Ddec=%h ptr=%0d neg=%b ovf=%b, want all 0", Ddec, ptr_dig, neg, ovf);
        end
        extra = 0;
        repeat (2 * LAT) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++;
        if (extra != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start: got %0d extra done pulses busy=%b, want 0 and 0", extra, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [NBIN-1:0] a, b;
        logic [4*NDIG-1:0] e_dec;
        logic e_neg, e_ovf;
        logic [3:0] e_ptr;
        int lat;
        int lowbusy;
        a = 27'd99999999;
        b = 27'h5A5A5A5;
        start(1'b0, a);
        wait_done(0, lat);
        start(1'b1, b);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart_busy: got busy=%b, want 1", busy);
        end
        lowbusy = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!done && !busy) lowbusy++;
        end while (!done && lat < 3 * LAT);
        model(1'b1, b, e_dec, e_neg, e_ovf, e_ptr);
        checks++;
        if (lat != LAT || lowbusy != 0) begin
            errors++;
            $display("FAIL b2b_latency: got lat=%0d idle_cycles=%0d, want lat=%0d idle_cycles=0", lat, lowbusy, LAT);
        end
        checks++;
        if (Ddec !== e_dec || neg !== e_neg || ovf !== e_ovf || ptr_dig !== e_ptr) begin
            errors++;
            $display("FAIL b2b_result: got Ddec=%h neg=%b ovf=%b ptr=%0d, want Ddec=%h neg=%b ovf=%b ptr=%0d",
                     Ddec, neg, ovf, ptr_dig, e_dec, e_neg, e_ovf, e_ptr);
        end
    endtask

    task automatic test_abort;
        logic [4*NDIG-1:0] e_dec;
        logic e_neg, e_ovf;
        logic [3:0] e_ptr;
        int lat;
        start(1'b0, 27'h3333333);
        repeat (9) @(negedge clk);
        #5 rst = 1'b1;
        #1;
        checks++;
        if ({Ddec, neg, ovf, ptr_dig, busy, done} !== '0) begin
            errors++;
            $display("FAIL abort_clear: got Ddec=%h neg=%b ovf=%b ptr=%0d busy=%b done=%b, want all 0",
                     Ddec, neg, ovf, ptr_dig, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        start(1'b1, 27'h6000001);
        wait_done(0, lat);
        model(1'b1, 27'h6000001, e_dec, e_neg, e_ovf, e_ptr);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL abort_restart_latency: got %0d, want %0d", lat, LAT);
        end
        checks++;
        if (Ddec !== e_dec || neg !== e_neg || ovf !== e_ovf || ptr_dig !== e_ptr) begin
            errors++;
            $display("FAIL abort_restart_result: got Ddec=%h neg=%b ovf=%b ptr=%0d, want Ddec=%h neg=%b ovf=%b ptr=%0d",
                     Ddec, neg, ovf, ptr_dig, e_dec, e_neg, e_ovf, e_ptr);
        end
    endtask

    task automatic test_random;
        logic [NBIN-1:0] d;
        logic s;
        logic [4*NDIG-1:0] e_dec;
        logic e_neg, e_ovf;
        logic [3:0] e_ptr;
        int lat;
        for (int n = 0; n < 40; n++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       d = NBIN'($urandom_range(0, 999));
                1:       d = NBIN'(100000000 + $urandom_range(0, 1000));
                2:       d = NBIN'(99999999 - $urandom_range(0, 3));
                default: d = NBIN'($urandom);
            endcase
            @(negedge clk);
            start(s, d);
            wait_done(0, lat);
            model(s, d, e_dec, e_neg, e_ovf, e_ptr);
            checks++;
            if (lat != LAT || Ddec !== e_dec || neg !== e_neg || ovf !== e_ovf || ptr_dig !== e_ptr) begin
                errors++;
                $display("FAIL rand%0d sgn=%b Dbin=%h: got lat=%0d Ddec=%h neg=%b ovf=%b ptr=%0d, want lat=%0d Ddec=%h neg=%b ovf=%b ptr=%0d",
                         n, s, d, lat, Ddec, neg, ovf, ptr_dig, LAT, e_dec, e_neg, e_ovf, e_ptr);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_vectors();
        test_zero_and_ignore();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
